// File: rtl/multi_port_fifo_switch.sv
// multi_port_fifo_switch: NUM_IN tagged input ports steered into NUM_OUT
// independent first-word-fall-through queues. Each queue has its own
// round-robin arbiter, occupancy counter and status flags.
module multi_port_fifo_switch #(
  parameter int DWIDTH    = 64,
  parameter int NUM_IN    = 4,
  parameter int NUM_OUT   = 4,
  parameter int AWIDTH    = 4,
  parameter int AEMPTY_TH = 2,
  parameter int AFULL_TH  = 2,
  localparam int DEST_W   = $clog2(NUM_OUT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_IN*DWIDTH-1:0]      in_data,
  input  logic [NUM_IN*DEST_W-1:0]      in_dest,
  input  logic [NUM_IN-1:0]             in_valid,
  output logic [NUM_IN-1:0]             in_ready,
  output logic [NUM_IN-1:0]             dest_err,
  input  logic [NUM_OUT-1:0]            pop,
  output logic [NUM_OUT*DWIDTH-1:0]     out_data,
  output logic [NUM_OUT-1:0]            empty,
  output logic [NUM_OUT-1:0]            almostempty,
  output logic [NUM_OUT-1:0]            full,
  output logic [NUM_OUT-1:0]            almostfull,
  output logic [NUM_OUT*(AWIDTH+1)-1:0] num
);

  localparam int DEPTH = 2**AWIDTH;
  localparam int CW    = AWIDTH + 1;
  localparam int RRW   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [DWIDTH-1:0] mem    [NUM_OUT][DEPTH];
  logic [CW-1:0]     count  [NUM_OUT];
  logic [AWIDTH-1:0] wr_ptr [NUM_OUT];
  logic [AWIDTH-1:0] rd_ptr [NUM_OUT];
  logic [RRW-1:0]    rr_ptr [NUM_OUT];

  logic [DEST_W-1:0] dest      [NUM_IN];
  logic [NUM_IN-1:0] bad_dest;
  logic [NUM_IN-1:0] granted;
  logic [NUM_OUT-1:0] wr_en;
  logic [NUM_OUT-1:0] rd_en;
  logic [RRW-1:0]    grant_idx [NUM_OUT];
  logic [DWIDTH-1:0] wr_word   [NUM_OUT];

  // Unpack destination tags and flag tags that name no existing queue
  always_comb begin
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      dest[i]     = in_dest[i*DEST_W +: DEST_W];
      bad_dest[i] = (32'(dest[i]) >= 32'(NUM_OUT));
    end
  end

  // Per-queue round-robin grant; a full queue still accepts when it is popped
  always_comb begin
    int unsigned idx;
    idx     = 0;
    wr_en   = '0;
    rd_en   = '0;
    granted = '0;
    for (int unsigned o = 0; o < NUM_OUT; o++) begin
      grant_idx[o] = '0;
      wr_word[o]   = '0;
      rd_en[o]     = pop[o] && (count[o] != '0);
      if ((count[o] != CW'(DEPTH)) || rd_en[o]) begin
        for (int unsigned k = 0; k < NUM_IN; k++) begin
          idx = (32'(rr_ptr[o]) + k) % 32'(NUM_IN);
          if (!wr_en[o] && in_valid[idx] && (dest[idx] == DEST_W'(o))) begin
            wr_en[o]     = 1'b1;
            grant_idx[o] = RRW'(idx);
            wr_word[o]   = in_data[idx*DWIDTH +: DWIDTH];
            granted[idx] = 1'b1;
          end
        end
      end
    end
  end

  // Ready: granted by the target queue, or the word is discarded for a bad tag
  always_comb begin
    in_ready = reset ? '0 : (granted | bad_dest);
  end

  // Pointer, count, arbiter and error-pulse state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dest_err <= '0;
      for (int unsigned o = 0; o < NUM_OUT; o++) begin
        count[o]  <= '0;
        wr_ptr[o] <= '0;
        rd_ptr[o] <= '0;
        rr_ptr[o] <= '0;
      end
    end else begin
      dest_err <= in_valid & bad_dest;
      for (int unsigned o = 0; o < NUM_OUT; o++) begin
        if (wr_en[o]) begin
          wr_ptr[o] <= wr_ptr[o] + AWIDTH'(1);
          rr_ptr[o] <= (32'(grant_idx[o]) == 32'(NUM_IN - 1)) ? '0
                                                              : grant_idx[o] + RRW'(1);
        end
        if (rd_en[o]) begin
          rd_ptr[o] <= rd_ptr[o] + AWIDTH'(1);
        end
        count[o] <= count[o] + CW'(wr_en[o]) - CW'(rd_en[o]);
      end
    end
  end

  // Queue storage, deliberately left out of reset
  always_ff @(posedge clk) begin
    for (int unsigned o = 0; o < NUM_OUT; o++) begin
      if (!reset && wr_en[o]) begin
        mem[o][wr_ptr[o]] <= wr_word[o];
      end
    end
  end

  // Head word, occupancy and flags decoded from the registered count
  always_comb begin
    out_data    = '0;
    num         = '0;
    empty       = '0;
    almostempty = '0;
    full        = '0;
    almostfull  = '0;
    for (int unsigned o = 0; o < NUM_OUT; o++) begin
      empty[o]       = (count[o] == '0);
      full[o]        = (count[o] == CW'(DEPTH));
      almostempty[o] = (32'(count[o]) <= 32'(AEMPTY_TH));
      almostfull[o]  = (32'(count[o]) >= 32'(DEPTH - AFULL_TH));
      num[o*CW +: CW] = count[o];
      if (count[o] != '0) begin
        out_data[o*DWIDTH +: DWIDTH] = mem[o][rd_ptr[o]];
      end
    end
  end

endmodule

// File: tb/tb_multi_port_fifo_switch.sv
// Testbench for multi_port_fifo_switch: queue-based reference model plus
// directed scenarios and randomized traffic; a second small instance with a
// non-power-of-two queue count exercises the bad-destination path.
module tb_multi_port_fifo_switch;

  localparam int DW = 64, NI = 4, NO = 4, AW = 4, DEPTH = 16, DSW = 2, CW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [NI*DW-1:0]  in_data;
  logic [NI*DSW-1:0] in_dest;
  logic [NI-1:0]     in_valid, in_ready, dest_err;
  logic [NO-1:0]     pop, empty, almostempty, full, almostfull;
  logic [NO*DW-1:0]  out_data;
  logic [NO*CW-1:0]  num;

  logic [15:0] in_data3;
  logic [3:0]  in_dest3;
  logic [1:0]  in_valid3, in_ready3, dest_err3;
  logic [2:0]  pop3, empty3, aempty3, full3, afull3;
  logic [23:0] out_data3;
  logic [8:0]  num3;

  multi_port_fifo_switch #(.DWIDTH(DW), .NUM_IN(NI), .NUM_OUT(NO), .AWIDTH(AW),
                           .AEMPTY_TH(2), .AFULL_TH(2)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_dest(in_dest),
    .in_valid(in_valid), .in_ready(in_ready), .dest_err(dest_err), .pop(pop),
    .out_data(out_data), .empty(empty), .almostempty(almostempty), .full(full),
    .almostfull(almostfull), .num(num));

  multi_port_fifo_switch #(.DWIDTH(8), .NUM_IN(2), .NUM_OUT(3), .AWIDTH(2),
                           .AEMPTY_TH(1), .AFULL_TH(1)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_dest(in_dest3),
    .in_valid(in_valid3), .in_ready(in_ready3), .dest_err(dest_err3), .pop(pop3),
    .out_data(out_data3), .empty(empty3), .almostempty(aempty3), .full(full3),
    .almostfull(afull3), .num(num3));

  always #5 clk = ~clk;

  logic [DW-1:0] mq [NO][$];
  int rr [NO];
  int gsel [NO];
  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int o = 0; o < NO; o++) begin
      mq[o].delete();
      rr[o] = 0;
      gsel[o] = -1;
    end
  endfunction

  // Which input each queue accepts this cycle (-1 for none)
  function automatic void model_grants();
    for (int o = 0; o < NO; o++) begin
      gsel[o] = -1;
      if (!reset && (mq[o].size() < DEPTH || pop[o])) begin
        for (int k = 0; k < NI; k++) begin
          int i;
          i = (rr[o] + k) % NI;
          if (gsel[o] < 0 && in_valid[i] && int'(in_dest[i*DSW +: DSW]) == o) gsel[o] = i;
        end
      end
    end
  endfunction

  function automatic void model_update();
    if (reset) begin
      model_clear();
      return;
    end
    for (int o = 0; o < NO; o++) begin
      if (pop[o] && mq[o].size() > 0) void'(mq[o].pop_front());
      if (gsel[o] >= 0) begin
        mq[o].push_back(in_data[gsel[o]*DW +: DW]);
        rr[o] = (gsel[o] + 1) % NI;
      end
    end
  endfunction

  task automatic compare_outputs();
    for (int o = 0; o < NO; o++) begin
      int n;
      logic [DW-1:0] exp_word;
      logic [3:0] ef;
      n = mq[o].size();
      exp_word = (n > 0) ? mq[o][0] : '0;
      ef = {n == 0, n <= 2, n == DEPTH, n >= DEPTH - 2};
      chk($sformatf("out_data[%0d]", o), out_data[o*DW +: DW], exp_word);
      chk($sformatf("num[%0d]", o), 64'(num[o*CW +: CW]), 64'(n));
      chk($sformatf("flags[%0d]", o), {empty[o], almostempty[o], full[o], almostfull[o]}, ef);
    end
    chk("dest_err", dest_err, '0);
  endtask

  // One clock: check ready against the model, take the edge, check outputs
  task automatic step();
    logic [NI-1:0] er;
    #1;
    model_grants();
    er = '0;
    for (int o = 0; o < NO; o++) if (gsel[o] >= 0) er[gsel[o]] = 1'b1;
    chk("in_ready", in_ready, er);
    @(posedge clk);
    model_update();
    #1;
    compare_outputs();
  endtask

  task automatic set_in(input int i, input logic v, input int d, input logic [DW-1:0] w);
    in_valid[i] = v;
    in_dest[i*DSW +: DSW] = DSW'(d);
    in_data[i*DW +: DW] = w;
  endtask

  task automatic clear_in();
    in_valid = '0;
    in_dest = '0;
    in_data = '0;
    pop = '0;
  endtask

  task automatic drain();
    clear_in();
    pop = '1;
    repeat (DEPTH + 1) step();
    pop = '0;
  endtask

  task automatic rand_in();
    for (int i = 0; i < NI; i++)
      set_in(i, 1'($urandom % 2), int'($urandom % 4), {$urandom(), $urandom()});
    pop = 4'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    in_data3 = '0; in_dest3 = '0; in_valid3 = '0; pop3 = '0;
    model_clear();
    reset = 1'b1;
    in_valid = '1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("in_ready_in_reset", in_ready, 0);
    end
    clear_in();
    reset = 1'b0;
    #1;
    chk("empty_rst", empty, 4'hF);
    chk("aempty_rst", almostempty, 4'hF);
    chk("full_rst", {full, almostfull}, 0);
    chk("num_rst", num, 0);
    chk("out_zero_rst", 64'(out_data != '0), 0);
    chk("ready_idle", in_ready, 0);

    // Bad destination on the three-queue instance
    in_dest3 = {2'd0, 2'd3}; in_valid3 = 2'b01; #1;
    chk("rdy3_bad", in_ready3, 2'b01);
    step();
    chk("dest_err3", dest_err3, 2'b01);
    chk("num3", num3, 0);
    chk("empty3", empty3, 3'b111);
    in_dest3 = {2'd2, 2'd3}; in_valid3 = 2'b11; in_data3 = {8'hA5, 8'h5A}; #1;
    chk("rdy3_mix", in_ready3, 2'b11);
    step();
    chk("dest_err3_mix", dest_err3, 2'b01);
    chk("num3_mix", num3, 9'b001_000_000);
    chk("out3_q2", out_data3[23:16], 8'hA5);
    in_valid3 = '0;
    step();
    chk("dest_err3_clr", dest_err3, 0);
    chk("num3_hold", num3, 9'b001_000_000);

    // Single stream into queue 2
    clear_in();
    for (int k = 0; k < DEPTH; k++) begin
      set_in(0, 1'b1, 2, 64'(k));
      step();
      if (k == 12) chk("afull_13", almostfull[2], 0);
      if (k == 13) chk("afull_14", almostfull[2], 1);
    end
    chk("full2", full[2], 1);
    chk("num2_16", num[2*CW +: CW], 16);
    set_in(0, 1'b1, 2, 64'd16); #1;
    chk("ready_when_full", in_ready[0], 0);
    step();
    clear_in();
    for (int j = 0; j < DEPTH; j++) begin
      chk("head2", out_data[2*DW +: DW], 64'(j));
      pop[2] = 1'b1;
      step();
    end
    pop = '0;
    chk("empty2", empty[2], 1);

    // Four inputs contending for queue 1 while it is popped every cycle
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < NI; i++) set_in(i, 1'b1, 1, 64'(256 * i + c));
      pop[1] = 1'b1; #1;
      chk("rr_grant", in_ready, 64'(1) << (c % 4));
      step();
      chk("num1_steady", num[1*CW +: CW], 1);
    end
    drain();

    // Each input to its own queue
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NI; i++) set_in(i, 1'b1, i, 64'(256 * i + c));
      #1;
      chk("parallel_ready", in_ready, 4'hF);
      step();
    end
    clear_in();
    for (int i = 0; i < NO; i++) begin
      chk("parallel_num", num[i*CW +: CW], 8);
      chk("parallel_head", out_data[i*DW +: DW], 64'(256 * i));
    end
    drain();

    // Full queue 0 with simultaneous push and pop, wrapping the pointers
    for (int k = 0; k < DEPTH; k++) begin
      set_in(0, 1'b1, 0, 64'(1000 + k));
      step();
    end
    for (int k = 0; k < 24; k++) begin
      set_in(0, 1'b1, 0, 64'(1016 + k));
      pop[0] = 1'b1;
      chk("fullpop_head", out_data[0 +: DW], 64'(1000 + k));
      #1;
      chk("fullpop_ready", in_ready[0], 1);
      step();
      chk("fullpop_num", num[0 +: CW], 16);
    end
    clear_in();
    for (int j = 0; j < DEPTH; j++) begin
      chk("wrap_head", out_data[0 +: DW], 64'(1024 + j));
      pop[0] = 1'b1;
      step();
    end
    pop = '0;

    // Pop on an empty queue
    pop[3] = 1'b1;
    step();
    chk("empty_pop_num", num[3*CW +: CW], 0);
    chk("empty_pop_flag", {empty[3], almostempty[3], full[3], almostfull[3]}, 4'b1100);
    pop = '0;

    // Random traffic
    repeat (400) begin
      rand_in();
      step();
    end

    // Asynchronous reset in the middle of traffic
    rand_in();
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_empty", empty, 4'hF);
    chk("midrst_num", num, 0);
    chk("midrst_ready", in_ready, 0);
    model_clear();
    step();
    reset = 1'b0;
    repeat (60) begin
      rand_in();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_port_fifo_switch.md
Name: multi_port_fifo_switch

Overview:
- Parametrised successor to the single-queue FIFO switch.
- NUM_IN input ports each present a word plus a destination tag. Each word is steered into one of NUM_OUT independent output FIFOs.
- Each output queue has its own round-robin arbiter and per-queue status flags.
- Inputs see per-port backpressure through a valid/ready handshake.

Parameters:
- DWIDTH, 64, data word width
- NUM_IN, 4, number of input ports (>=1)
- NUM_OUT, 4, number of output queues (>=2)
- AWIDTH, 4, queue address width; per-queue depth DEPTH = 2**AWIDTH
- AEMPTY_TH, 2, almostempty asserts when count <= AEMPTY_TH
- AFULL_TH, 2, almostfull asserts when count >= DEPTH-AFULL_TH
- Derived localparam: DEST_W = clog2(NUM_OUT)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high
- in_data  input  NUM_IN*DWIDTH  input words; port i at slice [i*DWIDTH +: DWIDTH]
- in_dest  input  NUM_IN*DEST_W  destination queue index per input
- in_valid  input  NUM_IN  input word valid
- in_ready  output  NUM_IN  input word accepted this cycle when in_valid is also high
- dest_err  output  NUM_IN  registered 1-cycle pulse: a word with dest >= NUM_OUT was discarded
- pop  input  NUM_OUT  dequeue head of queue o
- out_data  output  NUM_OUT*DWIDTH  head word of each queue (first-word fall-through)
- empty, almostempty, full, almostfull  output  NUM_OUT each  per-queue flags
- num  output  NUM_OUT*(AWIDTH+1)  per-queue occupancy, 0..DEPTH

Behaviour:
- Reset (asynchronous, immediate):
  - counts, read/write pointers and arbiter pointers cleared to 0.
  - empty=1, almostempty=1, full=0, almostfull=0, num=0, dest_err=0, out_data=0.
  - Queue storage is not reset.
  - Reset asserted mid-operation discards all queued words.
  - in_ready=0 while reset is high.
- Per-queue arbitration (queue o):
  - Requesters are inputs i with in_valid[i]=1 and in_dest[i]==o.
  - Writable when count<DEPTH, or count==DEPTH and pop[o]=1 (simultaneous pop frees the slot).
  - If writable, grant goes to the first requester at or after rr_ptr[o], searching cyclically.
  - On grant: the word is written at the write pointer and rr_ptr[o] <= granted+1, wrapping to 0 after NUM_IN-1.
  - rr_ptr[o] holds when there is no grant.
  - At most one write per queue per cycle. Different queues may each accept one word in the same cycle.
- in_ready[i] is combinational:
  - 1 if granted by its destination's arbiter.
  - 1 if in_dest[i] >= NUM_OUT; the word is dropped and dest_err[i] is set next cycle.
  - Otherwise 0.
  - in_ready never depends on the input's own in_ready; no combinational loop.
- Pop:
  - pop[o] with empty[o]=1 is ignored; no pointer move and no underflow.
  - pop[o]=1 with count>0 advances the read pointer.
- Count update per cycle: count <= count + write - valid_pop.
  - Simultaneous push and pop leaves the count unchanged and both pointers advance.
  - Pointers are AWIDTH bits and wrap naturally modulo DEPTH.
- Latency:
  - A word accepted at edge k appears on out_data[o] after edge k, provided the queue was empty.
  - empty falls and num increments after the same edge.
- out_data[o] = memory[rd_ptr] when !empty, else 0.
- All flags are decoded from the registered count:
  - full when count==DEPTH; empty when count==0.
  - almostempty and almostfull use the thresholds above; both may be high simultaneously when DEPTH is small.
- Ordering: words from one input to one queue leave in arrival order. No ordering is guaranteed across inputs.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, release -> all empty=1, almostempty=1, num=0, in_ready=0 with in_valid=0, out_data=0.
- Single stream: input 0 sends 0..15 to queue 2 with no pop -> after 16 accepts full[2]=1, num[2]=16, almostfull at count 14. The 17th word sees in_ready[0]=0. Popping 16 times returns 0..15 in order, then empty[2]=1.
- Contention: inputs 0..3 all continuously valid to queue 1, pop[1]=1 every cycle -> grants rotate 0,1,2,3,0…; each input's in_ready is high exactly once per 4 cycles; num[1] stays at 1.
- Parallel destinations: input i targets queue i, all valid for 8 cycles -> all in_ready=1 every cycle; each queue ends with num=8 and holds its own input's data.
- Full with simultaneous pop: queue 0 full (16 words), push and pop[0] in the same cycle -> in_ready=1, num stays 16, head advances by one word. Wrap-around verified after 40 total words with the data sequence intact.
- Boundary/error: pop on empty queue 3 -> num stays 0, no flag change. With NUM_OUT=3, in_dest=3 -> in_ready=1, dest_err pulses for 1 cycle, no queue count changes. Assert reset mid-stream -> all queues are empty at once.
